// File: rtl/mips_pkg.sv
// Shared MIPS32 definitions: opcodes, functs, ALU codes, mux encodings and the
// multicycle control-word decode used by the sequencer.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
      S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
   } state_t;

   typedef struct packed {
      logic       iorD;
      logic       memRead;
      logic       memWrite;
      logic       fetchPhase;
      logic       decodePhase;
      logic       regDst;
      logic       memtoReg;
      logic       regWrite;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] pcSrc;
      logic [1:0] aluOp;
      logic       branch;
      logic       pcWrite;
   } ctrl_t;

   // fetchPhase/decodePhase mark states whose strobes also depend on live inputs
   function automatic ctrl_t stateOutputs(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH:  begin c.memRead = 1'b1; c.aluSrcB = SRCB_FOUR; c.fetchPhase = 1'b1; end
         S_DECODE: begin c.aluSrcB = SRCB_IMMSH; c.decodePhase = 1'b1; end
         S_MEMADR: begin c.aluSrcA = 1'b1; c.aluSrcB = SRCB_IMM; end
         S_MEMRD:  begin c.iorD = 1'b1; c.memRead = 1'b1; end
         S_MEMWB:  begin c.regWrite = 1'b1; c.memtoReg = 1'b1; end
         S_MEMWR:  begin c.iorD = 1'b1; c.memWrite = 1'b1; end
         S_EXEC:   begin c.aluSrcA = 1'b1; c.aluOp = ALUOP_FUNCT; end
         S_ALUWB:  begin c.regWrite = 1'b1; c.regDst = 1'b1; end
         S_BRANCH: begin
            c.aluSrcA = 1'b1; c.aluOp = ALUOP_SUB; c.pcSrc = PCSRC_ALUOUT; c.branch = 1'b1;
         end
         S_ADDIEX: begin c.aluSrcA = 1'b1; c.aluSrcB = SRCB_IMM; end
         S_ADDIWB: c.regWrite = 1'b1;
         S_JUMP:   begin c.pcSrc = PCSRC_JUMP; c.pcWrite = 1'b1; end
         default:  c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU control decode from ALUOp and Funct; shared with the single-cycle core.
module alu_decoder
   import mips_pkg::*;
(
   input  logic [1:0] ALUOp,
   input  logic [5:0] Funct,
   output logic [2:0] ALU_control,
   output logic       illegal_funct
);

   logic [2:0] functCode;

   // illegal_funct reflects Funct alone so the sequencer can flag it before EXEC
   always_comb begin
      functCode     = ALU_ADD;
      illegal_funct = 1'b0;
      case (Funct)
         FN_ADD:  functCode = ALU_ADD;
         FN_SUB:  functCode = ALU_SUB;
         FN_AND:  functCode = ALU_AND;
         FN_OR:   functCode = ALU_OR;
         FN_SLT:  functCode = ALU_SLT;
         default: begin functCode = ALU_ADD; illegal_funct = 1'b1; end
      endcase
   end

   always_comb begin
      ALU_control = ALU_ADD;
      case (ALUOp)
         ALUOP_SUB:   ALU_control = ALU_SUB;
         ALUOP_FUNCT: ALU_control = functCode;
         default:     ALU_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS32 sequencer: registered state and control word, with the
// memory handshake, branch Zero and decode checks applied on the output side.
module multicycle_control_fsm
   import mips_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] Funct,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       PCEn,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSrc,
   output logic [2:0] ALU_control,
   output logic       illegal_instr
);

   state_t     state_q, state_d;
   ctrl_t      ctrl_q;
   logic [2:0] decodedAluControl;
   logic       illegalFunct;
   logic       knownOpcode;

   alu_decoder u_aluDecoder (
      .ALUOp         (ctrl_q.aluOp),
      .Funct         (Funct),
      .ALU_control   (decodedAluControl),
      .illegal_funct (illegalFunct)
   );

   always_comb begin
      knownOpcode = 1'b0;
      case (opcode)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: knownOpcode = 1'b1;
         default: knownOpcode = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  if (mem_ready) state_d = S_FETCH;
         S_EXEC:   state_d = S_ALUWB;
         S_ALUWB:  state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         S_ADDIEX: state_d = S_ADDIWB;
         S_ADDIWB: state_d = S_FETCH;
         S_JUMP:   state_d = S_FETCH;
         default:  state_d = S_FETCH;
      endcase
   end

   // The control word is decoded from the next state so it is valid at state entry
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         ctrl_q  <= stateOutputs(S_FETCH);
      end else begin
         state_q <= state_d;
         ctrl_q  <= stateOutputs(state_d);
      end
   end

   always_comb begin
      PCEn          = 1'b0;
      IorD          = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      RegDst        = 1'b0;
      MemtoReg      = 1'b0;
      RegWrite      = 1'b0;
      ALUSrcA       = 1'b0;
      ALUSrcB       = SRCB_REG;
      PCSrc         = PCSRC_ALU;
      ALU_control   = ALU_ADD;
      illegal_instr = 1'b0;
      if (!reset) begin
         IorD          = ctrl_q.iorD;
         MemRead       = ctrl_q.memRead;
         MemWrite      = ctrl_q.memWrite;
         IRWrite       = ctrl_q.fetchPhase & mem_ready;
         RegDst        = ctrl_q.regDst;
         MemtoReg      = ctrl_q.memtoReg;
         RegWrite      = ctrl_q.regWrite;
         ALUSrcA       = ctrl_q.aluSrcA;
         ALUSrcB       = ctrl_q.aluSrcB;
         PCSrc         = ctrl_q.pcSrc;
         ALU_control   = decodedAluControl;
         PCEn          = (ctrl_q.fetchPhase & mem_ready) | ctrl_q.pcWrite
                       | (ctrl_q.branch & Zero);
         illegal_instr = ctrl_q.decodePhase
                       & (~knownOpcode | ((opcode == OP_RTYPE) & illegalFunct));
      end
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for the multicycle sequencer: vector table, hand-written
// corner sequences and random instructions against an event-count model.
module tb_multicycle_control_fsm;

   logic       clk;
   logic       reset;
   logic [5:0] opcode;
   logic [5:0] Funct;
   logic       Zero;
   logic       mem_ready;
   logic       PCEn, IorD, MemRead, MemWrite, IRWrite;
   logic       RegDst, MemtoReg, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, PCSrc;
   logic [2:0] ALU_control;
   logic       illegal_instr;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic       pcEn, iorD, memRead, memWrite, irWrite, regDst, memtoReg, regWrite, aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] pcSrc;
      logic [2:0] aluCtl;
      logic       illegal;
   } snap_t;

   typedef struct {
      int cycles, irWrites, regWrites, memtoRegWrites, regDstWrites, memWriteCycles, pcEns, illegals;
   } tally_t;

   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      logic       z;
      int         f, m, cycles, rw, mtr, rd, mw, pc, ill;
   } vec_t;

   snap_t  nowOuts, resetOuts;
   snap_t  snap [0:31];
   tally_t obs, exp;
   int     violations;
   vec_t   vecs [0:12];

   assign nowOuts = {PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                     ALUSrcA, ALUSrcB, PCSrc, ALU_control, illegal_instr};

   multicycle_control_fsm dut (
      .clk(clk), .reset(reset), .opcode(opcode), .Funct(Funct), .Zero(Zero),
      .mem_ready(mem_ready), .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
      .ALU_control(ALU_control), .illegal_instr(illegal_instr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Instruction-level model: latency and how often each strobe should fire
   function automatic tally_t modelTally(input logic [5:0] op, input logic [5:0] fn,
                                         input logic z, input int f, input int m);
      tally_t t;
      t = '{default: 0};
      t.irWrites = 1;
      t.pcEns    = 1;
      case (op)
         6'b000000: begin t.cycles = 4; t.regWrites = 1; t.regDstWrites = 1; end
         6'b100011: begin t.cycles = 5 + m; t.regWrites = 1; t.memtoRegWrites = 1; end
         6'b101011: begin t.cycles = 4 + m; t.memWriteCycles = m + 1; end
         6'b000100: begin t.cycles = 3; if (z) t.pcEns = 2; end
         6'b001000: begin t.cycles = 4; t.regWrites = 1; end
         6'b000010: begin t.cycles = 3; t.pcEns = 2; end
         default:   begin t.cycles = 2; t.illegals = 1; end
      endcase
      if (op == 6'b000000 &&
          !(fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}))
         t.illegals = 1;
      t.cycles += f;
      return t;
   endfunction

   task automatic fetchCheck(input string name);
      mem_ready = 1'b0;
      @(negedge clk);
      checkOutput(name, int'({MemRead, IorD, ALUSrcA, ALUSrcB, IRWrite, PCEn, RegWrite, MemWrite}),
                  int'(9'b1_0_0_01_0_0_0_0));
      @(posedge clk); #1;
   endtask

   // Runs one instruction from FETCH: f fetch stalls, m data-memory stalls
   task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                input int f, input int m, input int cycles, input string tag);
      bit memOp;
      memOp  = (op == 6'b100011) || (op == 6'b101011);
      opcode = op;
      Funct  = fn;
      Zero   = z;
      obs = '{default: 0};
      violations = 0;
      for (int k = 0; k < cycles; k++) begin
         if (k < f)                                mem_ready = 1'b0;
         else if (k == f)                          mem_ready = 1'b1;
         else if (memOp && k >= f + 3 && k < f + 3 + m) mem_ready = 1'b0;
         else if (memOp && k == f + 3 + m)         mem_ready = 1'b1;
         else                                      mem_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (k < 32) snap[k] = nowOuts;
         obs.irWrites       += int'(IRWrite);
         obs.regWrites      += int'(RegWrite);
         obs.memtoRegWrites += int'(RegWrite & MemtoReg);
         obs.regDstWrites   += int'(RegWrite & RegDst);
         obs.memWriteCycles += int'(MemWrite & IorD);
         obs.pcEns          += int'(PCEn);
         obs.illegals       += int'(illegal_instr);
         violations         += int'(MemRead & MemWrite) + int'(PCEn & RegWrite);
         @(posedge clk); #1;
      end
      fetchCheck({tag, " next fetch"});
   endtask

   task automatic compareTally(input string tag, input tally_t e);
      checkOutput({tag, " irWrites"},  obs.irWrites,       e.irWrites);
      checkOutput({tag, " regWrites"}, obs.regWrites,      e.regWrites);
      checkOutput({tag, " memtoReg"},  obs.memtoRegWrites, e.memtoRegWrites);
      checkOutput({tag, " regDst"},    obs.regDstWrites,   e.regDstWrites);
      checkOutput({tag, " memWrite"},  obs.memWriteCycles, e.memWriteCycles);
      checkOutput({tag, " pcEn"},      obs.pcEns,          e.pcEns);
      checkOutput({tag, " illegal"},   obs.illegals,       e.illegals);
      checkOutput({tag, " exclusive"}, violations,         0);
   endtask

   initial begin
      resetOuts = '0;
      resetOuts.aluCtl = 3'b010;

      vecs[0]  = '{6'b000000, 6'b100000, 1'b0, 0, 0, 4,  1, 0, 1, 0, 1, 0};
      vecs[1]  = '{6'b000000, 6'b100010, 1'b0, 1, 0, 5,  1, 0, 1, 0, 1, 0};
      vecs[2]  = '{6'b000000, 6'b101010, 1'b1, 0, 0, 4,  1, 0, 1, 0, 1, 0};
      vecs[3]  = '{6'b100011, 6'b000000, 1'b0, 0, 0, 5,  1, 1, 0, 0, 1, 0};
      vecs[4]  = '{6'b100011, 6'b111111, 1'b0, 2, 3, 10, 1, 1, 0, 0, 1, 0};
      vecs[5]  = '{6'b101011, 6'b000000, 1'b0, 0, 2, 6,  0, 0, 0, 3, 1, 0};
      vecs[6]  = '{6'b000100, 6'b000000, 1'b1, 0, 0, 3,  0, 0, 0, 0, 2, 0};
      vecs[7]  = '{6'b000100, 6'b000000, 1'b0, 1, 0, 4,  0, 0, 0, 0, 1, 0};
      vecs[8]  = '{6'b001000, 6'b000000, 1'b0, 0, 0, 4,  1, 0, 0, 0, 1, 0};
      vecs[9]  = '{6'b000010, 6'b000000, 1'b0, 3, 0, 6,  0, 0, 0, 0, 2, 0};
      vecs[10] = '{6'b111111, 6'b100000, 1'b0, 0, 0, 2,  0, 0, 0, 0, 1, 1};
      vecs[11] = '{6'b000000, 6'b000000, 1'b0, 0, 0, 4,  1, 0, 1, 0, 1, 1};
      vecs[12] = '{6'b101011, 6'b000000, 1'b1, 1, 0, 5,  0, 0, 0, 1, 1, 0};

      reset = 1'b1; mem_ready = 1'b1; Zero = 1'b1; opcode = 6'b000000; Funct = 6'b000000;
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("reset outputs", int'(nowOuts), int'(resetOuts));
      @(posedge clk); #1;
      reset = 1'b0;
      fetchCheck("fetch after reset");

      // Reset during a stalled data read must abort straight back to FETCH
      opcode = 6'b100011; Zero = 1'b0; mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("memrd before reset", int'({MemRead, IorD, MemWrite}), int'(3'b110));
      @(posedge clk); #1;
      reset = 1'b1; mem_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput($sformatf("reset hold %0d", i), int'(nowOuts), int'(resetOuts));
         @(posedge clk); #1;
      end
      reset = 1'b0;
      fetchCheck("fetch after abort");

      for (int i = 0; i <= 12; i++) begin
         exp = '{vecs[i].cycles, 1, vecs[i].rw, vecs[i].mtr, vecs[i].rd,
                 vecs[i].mw, vecs[i].pc, vecs[i].ill};
         applyStimulus(vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].f, vecs[i].m,
                       vecs[i].cycles, $sformatf("vec%0d", i));
         compareTally($sformatf("vec%0d", i), exp);
      end

      applyStimulus(6'b000000, 6'b100000, 1'b0, 0, 0, 4, "add");
      checkOutput("add exec aluctl", int'(snap[2].aluCtl), 2);
      checkOutput("add exec srcA", int'(snap[2].aluSrcA), 1);
      checkOutput("add wb regwrite/regdst", int'({snap[3].regWrite, snap[3].regDst}), 3);

      applyStimulus(6'b000000, 6'b100010, 1'b0, 0, 0, 4, "sub");
      checkOutput("sub exec aluctl", int'(snap[2].aluCtl), 6);
      applyStimulus(6'b000000, 6'b100100, 1'b0, 0, 0, 4, "and");
      checkOutput("and exec aluctl", int'(snap[2].aluCtl), 0);
      applyStimulus(6'b000000, 6'b100101, 1'b0, 0, 0, 4, "or");
      checkOutput("or exec aluctl", int'(snap[2].aluCtl), 1);
      applyStimulus(6'b000000, 6'b101010, 1'b0, 0, 0, 4, "slt");
      checkOutput("slt exec aluctl", int'(snap[2].aluCtl), 7);

      applyStimulus(6'b000100, 6'b000000, 1'b1, 0, 0, 3, "beq taken");
      checkOutput("beq taken pcEn/pcSrc", int'({snap[2].pcEn, snap[2].pcSrc}), int'(3'b101));
      checkOutput("beq aluctl", int'(snap[2].aluCtl), 6);
      applyStimulus(6'b000100, 6'b000000, 1'b0, 0, 0, 3, "beq not taken");
      checkOutput("beq not taken pcEn", int'(snap[2].pcEn), 0);

      applyStimulus(6'b000010, 6'b000000, 1'b0, 0, 0, 3, "jump");
      checkOutput("jump pcEn/pcSrc", int'({snap[2].pcEn, snap[2].pcSrc}), int'(3'b110));

      applyStimulus(6'b101011, 6'b000000, 1'b0, 0, 2, 6, "sw stall");
      for (int k = 3; k < 6; k++)
         checkOutput($sformatf("sw memwrite cycle %0d", k),
                     int'({snap[k].memWrite, snap[k].iorD, snap[k].memRead}), int'(3'b110));
      checkOutput("sw no regwrite", obs.regWrites, 0);

      applyStimulus(6'b111111, 6'b100000, 1'b0, 0, 0, 2, "bad opcode");
      checkOutput("bad opcode pulse", int'(snap[1].illegal), 1);
      checkOutput("bad opcode fetch no pulse", int'(snap[0].illegal), 0);
      applyStimulus(6'b000000, 6'b000000, 1'b0, 0, 0, 4, "bad funct");
      checkOutput("bad funct pulse", int'(snap[1].illegal), 1);
      checkOutput("bad funct exec aluctl", int'(snap[2].aluCtl), 2);

      for (int i = 0; i < 60; i++) begin
         logic [5:0] ops [0:8];
         logic [5:0] fns [0:6];
         logic [5:0] op, fn;
         logic       z;
         int         f, m;
         ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000,
                 6'b000010, 6'b111111, 6'b000011, 6'b001101};
         fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                 6'b000000, 6'b100111};
         op = ops[$urandom_range(0, 8)];
         fn = fns[$urandom_range(0, 6)];
         z  = 1'($urandom_range(0, 1));
         f  = int'($urandom_range(0, 3));
         m  = int'($urandom_range(0, 3));
         exp = modelTally(op, fn, z, f, m);
         applyStimulus(op, fn, z, f, m, exp.cycles, $sformatf("rand%0d", i));
         compareTally($sformatf("rand%0d op=%b fn=%b", i, op, fn), exp);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
